// File: rtl/decode_stage.sv
// Decode stage: turns an opcode stream into registered, decoded fields with a
// valid/ready handshake on both sides. A load-next opcode takes two accepted
// words (opcode, then full-width immediate) and produces a single output.
module decode_stage #(
    parameter int IW   = 8,
    parameter int NREG = 4,
    parameter int RW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IW-1:0]   instr,
    input  logic            force_nop,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RW-1:0]   rs_read,
    output logic [RW-1:0]   rt_read,
    output logic            is_write,
    output logic [NREG-1:0] reg_write,
    output logic            is_short_imm,
    output logic            is_jump,
    output logic            is_load_next,
    output logic [IW-1:0]   imm,
    output logic [2:0]      alu_op
);

    // Width of the sign-extended short immediate field in class 01
    localparam int SW = IW - 2 - RW;
    localparam logic [IW-1:0] LOAD_NEXT_OPC = {1'b1, {(IW-1){1'b0}}};

    typedef enum logic {OPC, IMM} state_t;

    state_t state;

    logic [1:0]      cls;
    logic [RW-1:0]   rsf;
    logic [RW-1:0]   rtf;
    logic            ln_opcode;
    logic            accept;
    logic            load_out;

    logic [RW-1:0]   nxt_rs;
    logic [RW-1:0]   nxt_rt;
    logic            nxt_is_write;
    logic [NREG-1:0] nxt_reg_write;
    logic            nxt_is_short_imm;
    logic            nxt_is_jump;
    logic            nxt_is_load_next;
    logic [IW-1:0]   nxt_imm;
    logic [2:0]      nxt_alu_op;

    assign cls       = instr[IW-1:IW-2];
    assign rsf       = instr[2*RW-1:RW];
    assign rtf       = instr[RW-1:0];
    assign ln_opcode = (instr == LOAD_NEXT_OPC);
    assign in_ready  = !flush && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    // A genuine load-next opcode only arms IMM; the output is written with the trailing word
    assign load_out  = accept && !(state == OPC && !force_nop && ln_opcode);

    // Next output field set: load-next result in IMM, NOP under force_nop, else class decode
    always_comb begin
        nxt_rs           = '0;
        nxt_rt           = '0;
        nxt_is_write     = 1'b0;
        nxt_reg_write    = '0;
        nxt_is_short_imm = 1'b0;
        nxt_is_jump      = 1'b0;
        nxt_is_load_next = 1'b0;
        nxt_imm          = '0;
        nxt_alu_op       = '0;
        if (state == IMM) begin
            nxt_is_load_next = 1'b1;
            nxt_is_write     = 1'b1;
            nxt_reg_write[0] = 1'b1;
            nxt_alu_op       = 3'b101;
            nxt_imm          = instr;
        end else if (!force_nop) begin
            case (cls)
                2'b00: begin
                    nxt_rs               = rsf;
                    nxt_rt               = rtf;
                    nxt_alu_op           = {1'b0, instr[IW-3:IW-4]};
                    nxt_is_write         = 1'b1;
                    nxt_reg_write[rsf]   = 1'b1;
                end
                2'b01: begin
                    nxt_rs               = instr[IW-3:IW-2-RW];
                    nxt_imm              = {{(IW-SW){instr[SW-1]}}, instr[SW-1:0]};
                    nxt_is_short_imm     = 1'b1;
                    nxt_alu_op           = 3'b100;
                    nxt_is_write         = 1'b1;
                    nxt_reg_write[instr[IW-3:IW-2-RW]] = 1'b1;
                end
                2'b10: begin
                    if (!ln_opcode) begin
                        nxt_rs           = rsf;
                        nxt_rt           = rtf;
                        nxt_alu_op       = 3'b111;
                    end
                end
                default: begin
                    nxt_is_jump          = 1'b1;
                    nxt_rs               = rtf;
                end
            endcase
        end
    end

    // State machine and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= OPC;
            out_valid    <= 1'b0;
            rs_read      <= '0;
            rt_read      <= '0;
            is_write     <= 1'b0;
            reg_write    <= '0;
            is_short_imm <= 1'b0;
            is_jump      <= 1'b0;
            is_load_next <= 1'b0;
            imm          <= '0;
            alu_op       <= '0;
        end else if (flush) begin
            state     <= OPC;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                state <= (state == OPC && !force_nop && ln_opcode) ? IMM : OPC;
            end
            if (load_out) begin
                out_valid    <= 1'b1;
                rs_read      <= nxt_rs;
                rt_read      <= nxt_rt;
                is_write     <= nxt_is_write;
                reg_write    <= nxt_reg_write;
                is_short_imm <= nxt_is_short_imm;
                is_jump      <= nxt_is_jump;
                is_load_next <= nxt_is_load_next;
                imm          <= nxt_imm;
                alu_op       <= nxt_alu_op;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage at IW=8, NREG=4 with hand-computed expectations.
module tb_decode_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] instr;
    logic       force_nop;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] rs_read;
    logic [1:0] rt_read;
    logic       is_write;
    logic [3:0] reg_write;
    logic       is_short_imm;
    logic       is_jump;
    logic       is_load_next;
    logic [7:0] imm;
    logic [2:0] alu_op;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    decode_stage #(.IW(8), .NREG(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .force_nop(force_nop), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .rs_read(rs_read), .rt_read(rt_read), .is_write(is_write),
        .reg_write(reg_write), .is_short_imm(is_short_imm), .is_jump(is_jump),
        .is_load_next(is_load_next), .imm(imm), .alu_op(alu_op)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Full output bundle compare, packed {valid,rs,rt,isw,rw,si,j,ln,imm,alu}
    task automatic chk_out(input string tag, input logic v, input logic [1:0] rs,
                           input logic [1:0] rt, input logic w, input logic [3:0] rw,
                           input logic si, input logic j, input logic ln,
                           input logic [7:0] im, input logic [2:0] op);
        chk(tag,
            {8'h0, out_valid, rs_read, rt_read, is_write, reg_write, is_short_imm,
             is_jump, is_load_next, imm, alu_op},
            {8'h0, v, rs, rt, w, rw, si, j, ln, im, op});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; instr = 8'h00;
        force_nop = 1'b0; flush = 1'b0; out_ready = 1'b1;
        #12;
        chk_out("reset_outputs", 0, 0, 0, 0, 4'b0000, 0, 0, 0, 8'h00, 3'b000);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", in_ready, 1);

        // ALU
        in_valid = 1'b1; instr = 8'h1B;
        tick();
        chk_out("alu_1b", 1, 2, 3, 1, 4'b0100, 0, 0, 0, 8'h00, 3'b001);
        // short immediate, negative
        instr = 8'h5E;
        tick();
        chk_out("short_5e", 1, 1, 0, 1, 4'b0010, 1, 0, 0, 8'hFE, 3'b100);
        // short immediate, positive
        instr = 8'h65;
        tick();
        chk_out("short_65", 1, 2, 0, 1, 4'b0100, 1, 0, 0, 8'h05, 3'b100);
        // jump
        instr = 8'hC2;
        tick();
        chk_out("jump_c2", 1, 2, 0, 0, 4'b0000, 0, 1, 0, 8'h00, 3'b000);
        // compare
        instr = 8'h9B;
        tick();
        chk_out("cmp_9b", 1, 2, 3, 0, 4'b0000, 0, 0, 0, 8'h00, 3'b111);

        // load-next: no output after the opcode, one after the word
        instr = 8'h80;
        tick();
        chk("ln_no_out", out_valid, 0);
        instr = 8'h5A;
        tick();
        chk_out("ln_5a", 1, 0, 0, 1, 4'b0001, 0, 0, 1, 8'h5A, 3'b101);
        in_valid = 1'b0;
        tick();
        chk("ln_drained", out_valid, 0);

        // force_nop ignored on the trailing word
        in_valid = 1'b1; instr = 8'h80;
        tick();
        force_nop = 1'b1; instr = 8'h33;
        tick();
        force_nop = 1'b0;
        chk_out("ln_nop_ignored", 1, 0, 0, 1, 4'b0001, 0, 0, 1, 8'h33, 3'b101);

        // backpressure: hold 3 cycles, then back-to-back
        instr = 8'h1B;
        tick();
        out_ready = 1'b0; instr = 8'h5E;
        #1;
        chk("bp_ready_low", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("bp_hold", 1, 2, 3, 1, 4'b0100, 0, 0, 0, 8'h00, 3'b001);
            chk("bp_ready_hold", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_back", in_ready, 1);
        tick();
        chk_out("bp_next", 1, 1, 0, 1, 4'b0010, 1, 0, 0, 8'hFE, 3'b100);
        instr = 8'hC2;
        tick();
        chk_out("bp_b2b", 1, 2, 0, 0, 4'b0000, 0, 1, 0, 8'h00, 3'b000);
        in_valid = 1'b0;
        tick();
        chk("bp_drain", out_valid, 0);

        // flush mid load-next
        in_valid = 1'b1; instr = 8'h80;
        tick();
        flush = 1'b1; instr = 8'h5A;
        #1;
        chk("flush_ready", in_ready, 0);
        tick();
        chk("flush_valid", out_valid, 0);
        flush = 1'b0; instr = 8'h1B;
        tick();
        chk_out("flush_then_alu", 1, 2, 3, 1, 4'b0100, 0, 0, 0, 8'h00, 3'b001);

        // flush drops a held output regardless of out_ready
        out_ready = 1'b0; in_valid = 1'b0; flush = 1'b1;
        tick();
        chk("flush_held", out_valid, 0);
        flush = 1'b0; out_ready = 1'b1;

        // asynchronous reset clears a valid output before any edge
        in_valid = 1'b1; instr = 8'h1B; out_ready = 1'b0;
        tick();
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #2;
        chk_out("async_rst", 0, 0, 0, 0, 4'b0000, 0, 0, 0, 8'h00, 3'b000);
        rst_n = 1'b1; out_ready = 1'b1;

        // reset mid load-next
        instr = 8'h80;
        tick();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        instr = 8'h1B;
        tick();
        chk_out("rst_then_alu", 1, 2, 3, 1, 4'b0100, 0, 0, 0, 8'h00, 3'b001);

        // force_nop on a load-next opcode
        force_nop = 1'b1; instr = 8'h80;
        tick();
        chk_out("nop_80", 1, 0, 0, 0, 4'b0000, 0, 0, 0, 8'h00, 3'b000);
        force_nop = 1'b0; instr = 8'h1B;
        tick();
        chk_out("after_nop_alu", 1, 2, 3, 1, 4'b0100, 0, 0, 0, 8'h00, 3'b001);
        in_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter IW, default 8, instruction/immediate width in bits; legal when IW >= 2*RW+4.
REQ-002 Parameter NREG, default 4, register count, power of two >= 2.
REQ-003 Parameter RW, default $clog2(NREG), register-index width; derived, not overridden.
REQ-004 clk  input  1  single clock, all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  instr byte offered.
REQ-007 in_ready  output  1  stage accepts instr this cycle.
REQ-008 instr  input  IW  opcode or trailing immediate word.
REQ-009 force_nop  input  1  accepted opcode is decoded as NOP.
REQ-010 flush  input  1  discard output register and any pending load-next.
REQ-011 out_valid  output  1  decoded fields valid.
REQ-012 out_ready  input  1  consumer takes decoded fields.
REQ-013 rs_read, rt_read  output  RW each  source register indices.
REQ-014 is_write  output  1; reg_write  output  NREG  one-hot write enable, all-zero when is_write=0.
REQ-015 is_short_imm, is_jump, is_load_next  output  1 each  instruction class flags.
REQ-016 imm  output  IW  immediate (sign-extended short or full trailing word); alu_op  output  3.

Function
REQ-017 Fields: class = instr[IW-1:IW-2]; rsf = instr[2*RW-1:RW]; rtf = instr[RW-1:0].
REQ-018 Class 00 (ALU): rs=rsf, rt=rtf, alu_op={0,instr[IW-3:IW-4]}, is_write=1, write reg rsf.
REQ-019 Class 01 (short imm): rs=instr[IW-3:IW-2-RW], imm=sign-extend instr[IW-3-RW:0], is_short_imm=1, alu_op=3'b100, is_write=1, write reg rs.
REQ-020 Class 10, instr == {1,0...0} (load-next): is_load_next=1, is_write=1, write reg 0, alu_op=3'b101, imm = following word.
REQ-021 Class 10 otherwise (compare): rs=rsf, rt=rtf, alu_op=3'b111, is_write=0.
REQ-022 Class 11 (jump): is_jump=1, rs=rtf, is_write=0, alu_op=0.
REQ-023 Unused outputs are zero for each class; NOP = all outputs zero except out_valid.
REQ-024 FSM states: OPC (expect opcode), IMM (expect load-next immediate).
REQ-025 in_ready = !flush && (!out_valid || out_ready), in both states.
REQ-026 OPC, accept non-load-next opcode at edge N: output register loaded, out_valid=1 after edge N; latency 1.
REQ-027 OPC, accept load-next opcode (force_nop=0): no output; go to IMM; opcode fields held internally.
REQ-028 IMM, accept word at edge M: output register loaded with load-next fields, imm=word; go to OPC.
REQ-029 force_nop=1 on accepted opcode: NOP emitted, load-next opcode not treated as load-next, stay OPC; force_nop ignored in IMM.
REQ-030 Output register holds its value while out_valid=1 and out_ready=0; out_valid drops after edge with out_ready=1 and no new accept.
REQ-031 Simultaneous drain and accept: new fields replace old, out_valid stays 1, no bubble.
REQ-032 flush=1: out_valid=0 and state=OPC after edge, regardless of out_ready, in_valid or state.

Reset
REQ-033 rst_n=0: state=OPC, out_valid=0, all decoded outputs zero, immediately and asynchronously, including mid load-next.
REQ-034 First accept possible on first rising edge after rst_n deasserts; in_ready=1 then.

Verification
REQ-035 IW=8,NREG=4: instr 0x1B, out_ready=1 -> next cycle out_valid=1, alu_op=001, rs=2, rt=3, reg_write=0100.
REQ-036 instr 0x5E -> is_short_imm=1, rs=1, imm=0xFE, reg_write=0010; instr 0xC2 -> is_jump=1, is_write=0.
REQ-037 0x80 then 0x5A, out_ready=1 -> one output only, after second word: is_load_next=1, imm=0x5A, reg_write=0001.
REQ-038 out_ready=0 for 3 cycles after valid output -> in_ready=0, outputs stable; out_ready=1 with in_valid=1 -> back-to-back, no bubble.
REQ-039 0x80 accepted then flush=1 -> out_valid=0, next 0x1B decoded as ALU; repeat with rst_n=0 instead -> same result.
REQ-040 0x80 with force_nop=1 -> NOP output next cycle, state stays OPC, following 0x1B decoded normally.
